// File: rtl/synth_pkg.sv
// Shared types and constants for the time-multiplexed voice scheduler and its voice_phase slices.
package synth_pkg;

  localparam int CNT_W = 19;
  localparam logic [CNT_W-1:0] MIN_DIV = 19'd256;

  typedef enum logic [2:0] {
    MODE_OFF    = 3'd0,
    MODE_SQUARE = 3'd1,
    MODE_SAW    = 3'd2,
    MODE_TRI    = 3'd3
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_ACCUM,
    S_OUT
  } state_e;

endpackage

// File: rtl/voice_phase.sv
// Per-voice configuration and phase state: divisor/mode clamp, phase advance and period wrap.
// Build option VOICE_RETRIG_EN: a configuration write also restarts the voice phase.
module voice_phase
  import synth_pkg::*;
(
  input  logic             clk,
  input  logic             n_rst,
  input  logic             i_adv,
  input  logic             i_wr,
  input  logic [CNT_W-1:0] i_wr_divisor,
  input  logic [2:0]       i_wr_mode,
  output logic [CNT_W-1:0] o_count,
  output logic [CNT_W-1:0] o_divisor,
  output logic [7:0]       o_q,
  output mode_e            o_mode
);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_div;
  logic [CNT_W:0]   r_acc;
  logic [7:0]       r_q;
  mode_e            r_mode;

  logic [CNT_W:0]   w_acc_sum;
  logic [CNT_W:0]   w_acc_next;
  logic             w_carry;
  logic             w_wrap;

  // acc can sit just below a large divisor, so one extra bit holds acc + 256.
  assign w_acc_sum  = r_acc + (CNT_W+1)'(MIN_DIV);
  assign w_carry    = (w_acc_sum >= {1'b0, r_div});
  assign w_acc_next = w_carry ? (w_acc_sum - {1'b0, r_div}) : w_acc_sum;
  assign w_wrap     = (r_count == (r_div - CNT_W'(1)));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_count <= '0;
      r_acc   <= '0;
      r_q     <= '0;
      r_div   <= MIN_DIV;
      r_mode  <= MODE_OFF;
    end else begin
      if (i_adv) begin
        if (w_wrap) begin
          r_count <= '0;
          r_acc   <= '0;
          r_q     <= '0;
        end else begin
          r_count <= r_count + CNT_W'(1);
          r_acc   <= w_acc_next;
          r_q     <= r_q + {7'd0, w_carry};
        end
      end
      if (i_wr) begin
        r_div  <= (i_wr_divisor < MIN_DIV) ? MIN_DIV : i_wr_divisor;
        r_mode <= (i_wr_mode > 3'd3) ? MODE_OFF : mode_e'(i_wr_mode);
`ifdef VOICE_RETRIG_EN
        // NOTE: the later non-blocking assignment wins, so the restart overrides a same-cycle advance.
        r_count <= '0;
        r_acc   <= '0;
        r_q     <= '0;
`endif
      end
    end
  end

  assign o_count   = r_count;
  assign o_divisor = r_div;
  assign o_q       = r_q;
  assign o_mode    = r_mode;

endmodule

// File: rtl/voice_scheduler.sv
// Time-multiplexes NUM_VOICES voices onto one shared waveshaper and mixes them per sample frame.
// Build option VOICE_RETRIG_EN (see voice_phase): configuration writes restart the voice phase.
module voice_scheduler
  import synth_pkg::*;
#(
  parameter  int NUM_VOICES = 4,
  localparam int VW         = $clog2(NUM_VOICES)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             sample_tick,
  input  logic             wr_en,
  input  logic [VW-1:0]    wr_voice,
  input  logic [CNT_W-1:0] wr_divisor,
  input  logic [2:0]       wr_mode,
  output logic [CNT_W-1:0] ws_count,
  output logic [CNT_W-1:0] ws_divisor,
  output logic [7:0]       ws_Q,
  output logic [2:0]       ws_mode,
  input  logic [7:0]       ws_sample,
  output logic [7:0]       sample_out,
  output logic             sample_valid,
  output logic             busy,
  output logic             overrun
);

  state_e            r_state;
  state_e            w_next_state;
  logic [VW-1:0]     r_v;
  logic [8+VW-1:0]   r_mix;
  logic [7:0]        r_sample_out;
  logic              r_sample_valid;
  logic              r_overrun;

  logic [NUM_VOICES-1:0] w_adv;
  logic [NUM_VOICES-1:0] w_wr;
  logic [CNT_W-1:0]      w_count [NUM_VOICES];
  logic [CNT_W-1:0]      w_div   [NUM_VOICES];
  logic [7:0]            w_q     [NUM_VOICES];
  mode_e                 w_mode  [NUM_VOICES];

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
    assign w_adv[g] = (r_state == S_ACCUM) && (r_v == VW'(g));
    assign w_wr[g]  = wr_en && (wr_voice == VW'(g));

    voice_phase u_voice_phase (
      .clk          (clk),
      .n_rst        (n_rst),
      .i_adv        (w_adv[g]),
      .i_wr         (w_wr[g]),
      .i_wr_divisor (wr_divisor),
      .i_wr_mode    (wr_mode),
      .o_count      (w_count[g]),
      .o_divisor    (w_div[g]),
      .o_q          (w_q[g]),
      .o_mode       (w_mode[g])
    );
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    w_next_state = r_state;
    busy         = 1'b1;
    ws_count     = '0;
    ws_divisor   = '0;
    ws_Q         = '0;
    ws_mode      = MODE_OFF;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (sample_tick) w_next_state = S_DRIVE;
      end
      S_DRIVE, S_ACCUM: begin
        ws_count   = w_count[r_v];
        ws_divisor = w_div[r_v];
        ws_Q       = w_q[r_v];
        ws_mode    = w_mode[r_v];
        if (r_state == S_DRIVE)                w_next_state = S_ACCUM;
        else if (r_v == VW'(NUM_VOICES - 1))   w_next_state = S_OUT;
        else                                   w_next_state = S_DRIVE;
      end
      S_OUT:   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_v            <= '0;
      r_mix          <= '0;
      r_sample_out   <= '0;
      r_sample_valid <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      r_sample_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (sample_tick) begin
            r_v   <= '0;
            r_mix <= '0;
          end
        end
        S_ACCUM: begin
          r_mix <= r_mix + {{VW{1'b0}}, ws_sample};
          r_v   <= r_v + VW'(1);
        end
        S_OUT: begin
          r_sample_out   <= r_mix[8+VW-1:VW];
          r_sample_valid <= 1'b1;
        end
        default: ;
      endcase
      if (sample_tick && (r_state != S_IDLE)) r_overrun <= 1'b1;
    end
  end

  assign sample_out   = r_sample_out;
  assign sample_valid = r_sample_valid;
  assign overrun      = r_overrun;

endmodule
